// File: rtl/mode2_sub_ctrl.sv
// mode2_sub_ctrl: sequencer for the softmax (x - max) stage.
// Streams a row of packed 4-lane fp16 words from the input buffer through an external
// 4-lane combinational subtractor and buffers each result in a 2-entry output FIFO
// with valid/ready backpressure. Reads are credit-limited so the FIFO never overflows.
module mode2_sub_ctrl #(
   parameter int unsigned DATAWIDTH = 16,
   parameter int unsigned ADDRW     = 8
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   start,
   input  logic [ADDRW-1:0]       base_addr,
   input  logic [ADDRW-1:0]       num_words,
   input  logic [DATAWIDTH-1:0]   max_inp,
   output logic                   rd_en,
   output logic [ADDRW-1:0]       rd_addr,
   input  logic [4*DATAWIDTH-1:0] rd_data,
   output logic [DATAWIDTH-1:0]   sub_a0,
   output logic [DATAWIDTH-1:0]   sub_a1,
   output logic [DATAWIDTH-1:0]   sub_a2,
   output logic [DATAWIDTH-1:0]   sub_a3,
   output logic [DATAWIDTH-1:0]   sub_b,
   input  logic [DATAWIDTH-1:0]   sub_z0,
   input  logic [DATAWIDTH-1:0]   sub_z1,
   input  logic [DATAWIDTH-1:0]   sub_z2,
   input  logic [DATAWIDTH-1:0]   sub_z3,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [4*DATAWIDTH-1:0] out_data,
   output logic                   busy,
   output logic                   done
);

   localparam int unsigned WordW = 4 * DATAWIDTH;

   typedef enum logic [1:0] {StIdle, StRun, StDrain, StFin} state_e;

   state_e                 state_q, state_d;
   logic [ADDRW-1:0]       rd_addr_q, rd_addr_d;
   logic [ADDRW-1:0]       rem_q, rem_d;
   logic [DATAWIDTH-1:0]   max_q, max_d;
   logic                   inflight_q;
   logic [WordW-1:0]       fifo_mem_q [2];
   logic                   wr_ptr_q, rd_ptr_q;
   logic [1:0]             fifo_cnt_q, fifo_cnt_d;
   logic                   push, pop, issue;
   logic [2:0]             occupancy;

   // Datapath wiring: buffer lanes straight to the subtractors, latched max as b operand.
   assign sub_a0 = rd_data[0*DATAWIDTH +: DATAWIDTH];
   assign sub_a1 = rd_data[1*DATAWIDTH +: DATAWIDTH];
   assign sub_a2 = rd_data[2*DATAWIDTH +: DATAWIDTH];
   assign sub_a3 = rd_data[3*DATAWIDTH +: DATAWIDTH];
   assign sub_b  = max_q;

   // The word read last cycle is on rd_data now, so its result is captured this cycle.
   assign push      = inflight_q;
   assign pop       = out_valid & out_ready;
   assign out_valid = (fifo_cnt_q != 2'd0);
   assign out_data  = fifo_mem_q[rd_ptr_q];
   assign busy      = (state_q != StIdle);
   assign done      = (state_q == StFin);
   assign rd_en     = issue;
   assign rd_addr   = rd_addr_q;

   // Words buffered or in flight once this cycle's pop is accounted for; must stay below 2.
   assign occupancy = {1'b0, fifo_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};

   // FIFO occupancy next state.
   always_comb begin
      fifo_cnt_d = fifo_cnt_q;
      if (push && !pop) begin
         fifo_cnt_d = fifo_cnt_q + 2'd1;
      end else if (pop && !push) begin
         fifo_cnt_d = fifo_cnt_q - 2'd1;
      end
   end

   // Sequencer next state, read issue and row parameter capture.
   always_comb begin
      state_d   = state_q;
      rd_addr_d = rd_addr_q;
      rem_d     = rem_q;
      max_d     = max_q;
      issue     = 1'b0;
      case (state_q)
         StIdle: begin
            if (start) begin
               rd_addr_d = base_addr;
               rem_d     = num_words;
               max_d     = max_inp;
               // An empty row passes through the drain state so done lands two cycles out.
               state_d   = (num_words != '0) ? StRun : StDrain;
            end
         end
         StRun: begin
            if (occupancy < 3'd2) begin
               issue     = 1'b1;
               rd_addr_d = rd_addr_q + 1'b1;
               rem_d     = rem_q - 1'b1;
               if (rem_q == {{(ADDRW-1){1'b0}}, 1'b1}) begin
                  state_d = StDrain;
               end
            end
         end
         StDrain: begin
            // No reads are issued here, so an empty FIFO next cycle means the row is out.
            if (fifo_cnt_d == 2'd0) begin
               state_d = StFin;
            end
         end
         StFin: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Sequencer state and row registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= StIdle;
         rd_addr_q  <= '0;
         rem_q      <= '0;
         max_q      <= '0;
         inflight_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         rd_addr_q  <= rd_addr_d;
         rem_q      <= rem_d;
         max_q      <= max_d;
         inflight_q <= issue;
      end
   end

   // Two-entry output FIFO holding captured subtractor results.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         fifo_mem_q[0] <= '0;
         fifo_mem_q[1] <= '0;
         wr_ptr_q      <= 1'b0;
         rd_ptr_q      <= 1'b0;
         fifo_cnt_q    <= 2'd0;
      end else begin
         if (push) begin
            fifo_mem_q[wr_ptr_q] <= {sub_z3, sub_z2, sub_z1, sub_z0};
            wr_ptr_q             <= ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         fifo_cnt_q <= fifo_cnt_d;
      end
   end

   fifo_no_overflow: assert property (@(posedge clk) disable iff (!resetn)
      !(push && !pop && (fifo_cnt_q == 2'd2)));

endmodule

// File: tb/tb_mode2_sub_ctrl.sv
// Bench for mode2_sub_ctrl: small-integer fp16 subtractor stub, queue-based scoreboard,
// monitor that checks read addresses, credit limit, output order, hold stability and done.
module tb_mode2_sub_ctrl;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  base_addr = '0;
   logic [7:0]  num_words = '0;
   logic [15:0] max_inp = '0;
   logic        rd_en;
   logic [7:0]  rd_addr;
   logic [63:0] rd_data;
   logic [15:0] sub_a0, sub_a1, sub_a2, sub_a3, sub_b;
   logic [15:0] sub_z0, sub_z1, sub_z2, sub_z3;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [63:0] out_data;
   logic        busy, done;

   mode2_sub_ctrl #(.DATAWIDTH(16), .ADDRW(8)) dut (
      .clk(clk), .resetn(resetn), .start(start), .base_addr(base_addr),
      .num_words(num_words), .max_inp(max_inp), .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_data(rd_data), .sub_a0(sub_a0), .sub_a1(sub_a1), .sub_a2(sub_a2), .sub_a3(sub_a3),
      .sub_b(sub_b), .sub_z0(sub_z0), .sub_z1(sub_z1), .sub_z2(sub_z2), .sub_z3(sub_z3),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy),
      .done(done)
   );

   always #5 clk = ~clk;

   // fp16 encode of a small integer (|v| < 2048), exact.
   function automatic logic [15:0] fp16_of_int(input int v);
      int m;
      int e;
      logic [15:0] h;
      if (v == 0) return 16'h0000;
      m = (v < 0) ? -v : v;
      e = 0;
      for (int i = 1; i < 11; i++) if ((m >> i) != 0) e = i;
      h = 16'h0000;
      h[15] = (v < 0);
      h[14:10] = 5'(e + 15);
      h[9:0] = 10'((m << (10 - e)) & 32'h3FF);
      return h;
   endfunction

   // fp16 decode for integer-valued operands.
   function automatic int int_of_fp16(input logic [15:0] h);
      int e;
      int m;
      if (h[14:0] == 15'd0) return 0;
      e = int'(h[14:10]) - 15;
      if (e < 0) return 0;
      if (e > 10) e = 10;
      m = (32'h400 | int'(h[9:0])) >> (10 - e);
      return h[15] ? -m : m;
   endfunction

   // Stand-in for the external subtractors (exact for integer operands).
   always_comb begin
      sub_z0 = fp16_of_int(int_of_fp16(sub_a0) - int_of_fp16(sub_b));
      sub_z1 = fp16_of_int(int_of_fp16(sub_a1) - int_of_fp16(sub_b));
      sub_z2 = fp16_of_int(int_of_fp16(sub_a2) - int_of_fp16(sub_b));
      sub_z3 = fp16_of_int(int_of_fp16(sub_a3) - int_of_fp16(sub_b));
   end

   // Input buffer: one-cycle read latency.
   logic [63:0] mem [256];
   always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad = 0;
   logic [63:0] exp_q[$];
   bit          last_q[$];
   logic [7:0]  addr_q[$];
   int          empty_done_cyc = -10;
   int          ready_mode = 0;
   int          ridx = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%h want=%h cyc=%0d", name, got, want, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      total++;
      bad++;
      $display("FAIL %s: unexpected event cyc=%0d", name, cyc);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rd_en"}, rd_en, 0);
      check({tag, "_rd_addr"}, rd_addr, 0);
      check({tag, "_sub_b"}, sub_b, 0);
      check({tag, "_valid"}, out_valid, 0);
      check({tag, "_data"}, out_data, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
   endtask

   // Downstream ready pattern.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0: out_ready = 1'b1;
            1: begin
               out_ready = (ridx % 3 == 0);
               ridx++;
            end
            default: out_ready = ($urandom_range(0, 9) < 7);
         endcase
      end
   end

   // Monitor: compares everything the DUT presents against the queued expectations.
   initial begin
      bit          last_prev;
      bit          stall_prev;
      logic [63:0] data_prev;
      int          issued;
      int          xfer;
      bit          p;
      last_prev = 0; stall_prev = 0; data_prev = '0; issued = 0; xfer = 0;
      forever begin
         @(negedge clk);
         if (!resetn) begin
            last_prev = 0; stall_prev = 0; issued = 0; xfer = 0;
            continue;
         end
         check("done", done, (last_prev || (cyc == empty_done_cyc)));
         last_prev = 0;
         if (stall_prev) begin
            check("hold_valid", out_valid, 1);
            check("hold_data", out_data, data_prev);
         end
         p = out_valid && out_ready;
         if (rd_en) begin
            if (addr_q.size() == 0) fail_now("rd_unexpected");
            else check("rd_addr", rd_addr, addr_q.pop_front());
            check("credit", ((issued - xfer - int'(p)) < 2), 1);
            issued++;
         end
         if (p) begin
            if (exp_q.size() == 0) fail_now("out_unexpected");
            else begin
               check("out_data", out_data, exp_q.pop_front());
               last_prev = last_q.pop_front();
            end
            xfer++;
         end
         stall_prev = out_valid && !out_ready;
         data_prev = out_data;
      end
   end

   // Reference model: word k of the row is mem[base+k] with every lane reduced by max.
   task automatic issue_row(input logic [7:0] b, input logic [7:0] n, input logic [15:0] mx);
      int          mi;
      logic [7:0]  a;
      logic [63:0] w;
      mi = int_of_fp16(mx);
      for (int k = 0; k < int'(n); k++) begin
         a = b + 8'(k);
         for (int l = 0; l < 4; l++) w[16*l +: 16] = fp16_of_int(int_of_fp16(mem[a][16*l +: 16]) - mi);
         addr_q.push_back(a);
         exp_q.push_back(w);
         last_q.push_back(k == int'(n) - 1);
      end
      @(posedge clk);
      #1;
      start = 1'b1; base_addr = b; num_words = n; max_inp = mx;
      if (n == 0) empty_done_cyc = cyc + 2;
      @(posedge clk);
      #1;
      start = 1'b0; base_addr = 8'($urandom); num_words = 8'($urandom); max_inp = 16'($urandom);
   endtask

   task automatic wait_done(input int limit);
      int i;
      for (i = 0; i < limit; i++) begin
         @(negedge clk);
         if (done) break;
      end
      if (i == limit) fail_now("done_timeout");
      @(posedge clk);
      #1;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 256; i++)
         for (int l = 0; l < 4; l++) mem[i][16*l +: 16] = fp16_of_int($urandom_range(0, 15));
      for (int i = 16; i < 19; i++) mem[i] = {4{16'h4200}};

      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("por");
      resetn = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // T2 stream with exact latency checks.
      ready_mode = 0;
      issue_row(8'h10, 8'd3, 16'h4000);
      for (int j = 1; j <= 6; j++) begin
         @(negedge clk);
         check("t2_rd_en", rd_en, (j <= 3));
         check("t2_valid", out_valid, (j >= 3 && j <= 5));
         if (j >= 3 && j <= 5) check("t2_lanes", out_data, {4{16'h3C00}});
      end
      @(posedge clk);
      #1;

      // T1 asynchronous reset mid-row.
      issue_row(8'h20, 8'd8, 16'h4400);
      repeat (2) @(posedge clk);
      #1;
      resetn = 1'b0;
      #1;
      check_reset_outputs("t1");
      exp_q.delete(); last_q.delete(); addr_q.delete();
      @(posedge clk);
      #1;
      check_reset_outputs("t1b");
      resetn = 1'b1;
      repeat (3) @(posedge clk);
      #1;

      // T3 backpressure.
      ready_mode = 1;
      issue_row(8'h30, 8'd6, fp16_of_int(5));
      wait_done(200);

      // T4 empty row.
      ready_mode = 0;
      issue_row(8'h50, 8'd0, fp16_of_int(3));
      wait_done(10);

      // T5 start while busy is ignored.
      issue_row(8'h40, 8'd5, fp16_of_int(7));
      @(posedge clk);
      #1;
      start = 1'b1; base_addr = 8'h80; num_words = 8'd3; max_inp = fp16_of_int(1);
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(100);
      repeat (3) @(posedge clk);
      #1;

      // T6 address wrap.
      for (int i = 0; i < 4; i++) mem[8'(8'hFE + i)] = '0;
      issue_row(8'hFE, 8'd4, 16'hC000);
      wait_done(100);

      // Randomized rows under random backpressure.
      ready_mode = 2;
      for (int r = 0; r < 12; r++) begin
         issue_row(8'($urandom), 8'($urandom_range(1, 8)), fp16_of_int($urandom_range(0, 15)));
         wait_done(300);
      end

      repeat (4) @(posedge clk);
      check("sb_drained", exp_q.size(), 0);
      check("addr_drained", addr_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
